// File: rtl/pwm_compare.sv
// -----------------------------------------------------------------------------
// pwm_compare
//
// Turns the value of a free-running counter into a registered PWM waveform.
// A duty word is taken in through a valid/ready handshake and held in a
// pending slot. It becomes the active duty only on a counter wrap, so a
// period never changes duty part-way through. The block also emits a
// one-cycle strobe at the start of each period while it is enabled.
//
// Ports
//   i_clk          clock, same domain as the counter
//   i_reset        asynchronous, active-high reset
//   i_count        sampled counter value (wraps 2^CNT_WIDTH-1 -> 0)
//   i_enable       1 = generate PWM, 0 = return to IDLE
//   i_duty_valid   duty word offered by the producer
//   i_duty         duty word: high time in clocks per period
//   o_duty_ready   1 = pending slot empty, so a valid word is taken this cycle
//   o_pwm          registered PWM output
//   o_period_start one-cycle strobe on each wrap seen in ARMED or RUN
//   o_running      1 while in RUN
// -----------------------------------------------------------------------------
module pwm_compare #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CNT_WIDTH-1:0] i_count,
  input  logic                 i_enable,
  input  logic                 i_duty_valid,
  input  logic [CNT_WIDTH-1:0] i_duty,
  output logic                 o_duty_ready,
  output logic                 o_pwm,
  output logic                 o_period_start,
  output logic                 o_running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Unsigned compare. A duty of 0 never drives high, and the largest duty
  // still leaves one low count per period, so 100% duty is not reachable.
  function automatic logic duty_compare(input logic [CNT_WIDTH-1:0] count,
                                        input logic [CNT_WIDTH-1:0] duty);
    return (count < duty);
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   prev_count_q, prev_count_d;
  logic [CNT_WIDTH-1:0]   active_duty_q, active_duty_d;
  logic [CNT_WIDTH-1:0]   pending_duty_q, pending_duty_d;
  logic                   pending_full_q, pending_full_d;
  logic                   duty_ready_q, duty_ready_d;
  logic                   pwm_q, pwm_d;
  logic                   period_start_q, period_start_d;
  logic                   running_q, running_d;

  logic                   wrap;
  logic                   accept;
  logic                   load_active;
  logic [CNT_WIDTH-1:0]   eff_duty;

  always_comb begin
    // A wrap is the first cycle at zero. Because prev_count tracks the input
    // every cycle, a counter held at zero produces exactly one wrap.
    wrap        = (i_count == '0) && (prev_count_q != '0);
    // Ready is the registered inverse of pending_full, so an accept can never
    // land on the same cycle as a pending->active move.
    accept      = i_duty_valid && duty_ready_q;
    load_active = wrap && pending_full_q;
    // The count-0 compare on a wrap uses the word being promoted, so the new
    // period starts cleanly with the new duty.
    eff_duty    = load_active ? pending_duty_q : active_duty_q;

    prev_count_d   = i_count;
    active_duty_d  = load_active ? pending_duty_q : active_duty_q;
    pending_duty_d = accept ? i_duty : pending_duty_q;

    pending_full_d = pending_full_q;
    if (load_active) begin
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_full_d = 1'b1;
    end
    duty_ready_d = ~pending_full_d;

    state_d        = state_q;
    pwm_d          = 1'b0;
    period_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d        = ST_RUN;
          period_start_d = 1'b1;
          pwm_d          = duty_compare(i_count, eff_duty);
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          period_start_d = wrap;
          pwm_d          = duty_compare(i_count, eff_duty);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      prev_count_q   <= '1;
      active_duty_q  <= '0;
      pending_duty_q <= '0;
      pending_full_q <= 1'b0;
      duty_ready_q   <= 1'b1;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= prev_count_d;
      active_duty_q  <= active_duty_d;
      pending_duty_q <= pending_duty_d;
      pending_full_q <= pending_full_d;
      duty_ready_q   <= duty_ready_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      running_q      <= running_d;
    end
  end

  assign o_duty_ready   = duty_ready_q;
  assign o_pwm          = pwm_q;
  assign o_period_start = period_start_q;
  assign o_running      = running_q;

endmodule

// File: tb/tb_pwm_compare.sv
// -----------------------------------------------------------------------------
// tb_pwm_compare
//
// Self-checking bench for pwm_compare. The bench owns the counter, works out
// the expected output word for every clock from a behavioural reference and
// queues it, then compares it against the DUT one edge later. Scenario tasks
// add direct checks on period length, high time and handshake behaviour.
// -----------------------------------------------------------------------------
module tb_pwm_compare;

  localparam int W = 8;

  logic         clk;
  logic         i_reset;
  logic [W-1:0] i_count;
  logic         i_enable;
  logic         i_duty_valid;
  logic [W-1:0] i_duty;
  logic         o_duty_ready;
  logic         o_pwm;
  logic         o_period_start;
  logic         o_running;

  pwm_compare #(.CNT_WIDTH(W)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_count        (i_count),
    .i_enable       (i_enable),
    .i_duty_valid   (i_duty_valid),
    .i_duty         (i_duty),
    .o_duty_ready   (o_duty_ready),
    .o_pwm          (o_pwm),
    .o_period_start (o_period_start),
    .o_running      (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Bench-owned counter
  logic [W-1:0] cnt  = '0;
  bit           hold = 1'b0;

  // Reference state
  logic [W-1:0] m_prev;
  int           m_st;      // 0 idle, 1 armed, 2 run
  logic [W-1:0] m_active;
  logic [W-1:0] m_pend;
  bit           m_full;

  // Expected output words {pwm, period_start, running, duty_ready}
  logic [3:0]   exp_q[$];

  // Period statistics measured between period_start strobes
  int hi_acc, len_acc, last_hi, last_len, ps_total;

  task automatic model_reset();
    m_prev   = '1;
    m_st     = 0;
    m_active = '0;
    m_pend   = '0;
    m_full   = 1'b0;
    hi_acc   = 0;
    len_acc  = 0;
    last_hi  = -1;
    last_len = -1;
  endtask

  // One clock: drive count, queue expectation, clock, compare.
  task automatic step();
    logic [3:0]   e;
    logic [3:0]   o;
    logic [W-1:0] eff;
    bit           wrap, acc, xfer, pwm_e, ps_e;
    int           st_n;
    if (hold) cnt = '0;
    i_count = cnt;

    wrap  = (i_count == 0) && (m_prev != 0);
    acc   = i_duty_valid && !m_full;
    xfer  = wrap && m_full;
    eff   = xfer ? m_pend : m_active;
    pwm_e = 1'b0;
    ps_e  = 1'b0;
    st_n  = m_st;
    case (m_st)
      0: if (i_enable) st_n = 1;
      1: begin
        if (!i_enable) st_n = 0;
        else if (wrap) begin
          st_n  = 2;
          ps_e  = 1'b1;
          pwm_e = (i_count < eff);
        end
      end
      default: begin
        if (!i_enable) st_n = 0;
        else begin
          pwm_e = (i_count < eff);
          ps_e  = wrap;
        end
      end
    endcase
    if (xfer) m_active = m_pend;
    if (acc)  m_pend   = i_duty;
    if (xfer)     m_full = 1'b0;
    else if (acc) m_full = 1'b1;
    m_prev = i_count;
    m_st   = st_n;
    e = {pwm_e, ps_e, (st_n == 2), !m_full};
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    o = {o_pwm, o_period_start, o_running, o_duty_ready};
    e = exp_q.pop_front();
    tests++;
    if (o !== e) begin
      failed++;
      $display("FAIL cycle_outputs count=%0d got pwm/ps/run/rdy=%b required %b",
               i_count, o, e);
    end

    if (o_period_start === 1'b1) begin
      last_hi  = hi_acc;
      last_len = len_acc;
      hi_acc   = 0;
      len_acc  = 0;
      ps_total++;
    end
    if (o_pwm === 1'b1) hi_acc++;
    len_acc++;

    if (!hold) cnt = cnt + 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_count(input logic [W-1:0] target);
    for (int i = 0; i < 300 && cnt != target; i++) step();
  endtask

  task automatic wait_ps(input string name);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    while (n < 300 && !seen) begin
      step();
      n++;
      if (o_period_start === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL %s period_start timeout: none in %0d cycles, required within 300", name, n);
    end
  endtask

  task automatic load_duty(input logic [W-1:0] d);
    i_duty_valid = 1'b1;
    i_duty       = d;
    step();
    i_duty_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_enable     = 1'b0;
    i_duty_valid = 1'b0;
    i_reset      = 1'b1;
    model_reset();
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic check_period(input string name, input int hi, input int len);
    tests++;
    if (last_hi != hi) begin
      failed++;
      $display("FAIL %s high_time got %0d required %0d", name, last_hi, hi);
    end
    tests++;
    if (last_len != len) begin
      failed++;
      $display("FAIL %s period_len got %0d required %0d", name, last_len, len);
    end
  endtask

  task automatic test_reset();
    logic [3:0] o;
    i_reset      = 1'b1;
    i_enable     = 1'b0;
    i_duty_valid = 1'b0;
    i_duty       = '0;
    i_count      = '0;
    model_reset();
    #2;
    o = {o_pwm, o_period_start, o_running, o_duty_ready};
    tests++;
    if (o !== 4'b0001) begin
      failed++;
      $display("FAIL reset_values got pwm/ps/run/rdy=%b required 0001", o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    load_duty(8'd64);
    i_enable = 1'b1;
    wait_ps("basic_entry");
    wait_ps("basic_p1");
    check_period("basic_p1", 64, 256);
    wait_ps("basic_p2");
    check_period("basic_p2", 64, 256);
  endtask

  task automatic test_duty_extremes();
    do_reset();
    load_duty(8'd255);
    i_enable = 1'b1;
    wait_ps("max_entry");
    wait_ps("max_p1");
    check_period("duty_255", 255, 256);
    load_duty(8'd0);
    wait_ps("zero_a");
    wait_ps("zero_b");
    check_period("duty_0", 0, 256);
  endtask

  task automatic test_duty_update();
    do_reset();
    load_duty(8'd50);
    i_enable = 1'b1;
    wait_ps("upd_entry");
    wait_ps("upd_p1");
    check_period("upd_base", 50, 256);
    run_to_count(8'd128);
    load_duty(8'd100);
    // Offer a second word while the slot is full; it must be ignored.
    i_duty_valid = 1'b1;
    i_duty       = 8'd200;
    steps(10);
    i_duty_valid = 1'b0;
    tests++;
    if (o_duty_ready !== 1'b0) begin
      failed++;
      $display("FAIL upd_ready_low got %b required 0", o_duty_ready);
    end
    wait_ps("upd_cur");
    check_period("upd_current", 50, 256);
    tests++;
    if (o_duty_ready !== 1'b1) begin
      failed++;
      $display("FAIL upd_ready_after_wrap got %b required 1", o_duty_ready);
    end
    wait_ps("upd_next");
    check_period("upd_next", 100, 256);
  endtask

  task automatic test_counter_hold();
    int ps_before;
    do_reset();
    load_duty(8'd64);
    i_enable = 1'b1;
    wait_ps("hold_entry");
    wait_ps("hold_p1");
    run_to_count(8'd100);
    ps_before = ps_total;
    hold = 1'b1;
    steps(11);
    hold = 1'b0;
    steps(50);
    tests++;
    if (ps_total - ps_before != 1) begin
      failed++;
      $display("FAIL hold_strobes got %0d required 1", ps_total - ps_before);
    end
    wait_ps("hold_a");
    wait_ps("hold_b");
    check_period("hold_resume", 64, 256);
  endtask

  task automatic test_enable_drop();
    do_reset();
    load_duty(8'd128);
    i_enable = 1'b1;
    wait_ps("en_entry");
    wait_ps("en_p1");
    run_to_count(8'd20);
    i_enable = 1'b0;
    step();
    tests++;
    if ({o_pwm, o_running} !== 2'b00) begin
      failed++;
      $display("FAIL enable_drop got pwm/run=%b required 00", {o_pwm, o_running});
    end
    steps(5);
    i_enable = 1'b1;
    run_to_count(8'd200);
    tests++;
    if ({o_pwm, o_running} !== 2'b00) begin
      failed++;
      $display("FAIL armed_wait got pwm/run=%b required 00", {o_pwm, o_running});
    end
    wait_ps("en_rearm");
    tests++;
    if ({o_pwm, o_running} !== 2'b11) begin
      failed++;
      $display("FAIL rearm_run got pwm/run=%b required 11", {o_pwm, o_running});
    end
  endtask

  task automatic test_reset_pending();
    logic [3:0] o;
    do_reset();
    load_duty(8'd64);
    i_enable = 1'b1;
    wait_ps("rp_entry");
    wait_ps("rp_p1");
    run_to_count(8'd30);
    load_duty(8'd100);
    steps(3);
    tests++;
    if (o_duty_ready !== 1'b0) begin
      failed++;
      $display("FAIL rp_pending_full got ready=%b required 0", o_duty_ready);
    end
    // Reset asserted mid-cycle, away from any clock edge.
    #2;
    i_reset = 1'b1;
    model_reset();
    exp_q.delete();
    #1;
    o = {o_pwm, o_period_start, o_running, o_duty_ready};
    tests++;
    if (o !== 4'b0001) begin
      failed++;
      $display("FAIL rp_async_reset got pwm/ps/run/rdy=%b required 0001", o);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    wait_ps("rp_a");
    wait_ps("rp_b");
    check_period("rp_active_zero", 0, 256);
    tests++;
    if (o_duty_ready !== 1'b1) begin
      failed++;
      $display("FAIL rp_ready got %b required 1", o_duty_ready);
    end
  endtask

  initial begin
    ps_total = 0;
    test_reset();
    test_basic();
    test_duty_extremes();
    test_duty_update();
    test_counter_hold();
    test_enable_drop();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
